// File: rtl/mem_write_buffer_if.sv
// mem_write_buffer_if
//   Bus bundle between the cache's memory port, the write buffer and main
//   memory.
//   slave  : the write buffer's view. It takes cache requests and memory
//            responses, and drives refill data, completion, memory requests
//            and occupancy.
//   master : the environment's view (the cache plus main memory).
//   Signals:
//     c_read/c_write/c_addr/c_wdata      cache request, level-held until c_ready
//     c_rdata/c_ready                    refill data and one-cycle completion
//     mem_read/mem_write/mem_addr/
//       mem_wdata                        memory request, held until mem_ready
//     mem_rdata/mem_ready                memory read data, one-cycle completion
//     wb_count/wb_empty                  buffer occupancy
interface mem_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 28,
  parameter int DW    = 128
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          c_read;
  logic          c_write;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [CW-1:0] wb_count;
  logic          wb_empty;

  modport slave (
    input  c_read, c_write, c_addr, c_wdata, mem_rdata, mem_ready,
    output c_rdata, c_ready, mem_read, mem_write, mem_addr, mem_wdata,
           wb_count, wb_empty
  );

  modport master (
    output c_read, c_write, c_addr, c_wdata, mem_rdata, mem_ready,
    input  c_rdata, c_ready, mem_read, mem_write, mem_addr, mem_wdata,
           wb_count, wb_empty
  );
endinterface

// File: rtl/mem_write_buffer.sv
// mem_write_buffer
//   Write-back buffer between the cache and main memory. Dirty-block
//   write-backs go into a DEPTH-entry FIFO and complete in one cycle. The
//   FIFO drains to memory in the background. Refill reads are forwarded from
//   the youngest matching entry; a read with no match bypasses the FIFO and
//   goes to memory ahead of any pending drain.
//   Ports:
//     clk         system clock
//     proc_reset  asynchronous active-high reset
//     bus         mem_write_buffer_if.slave (cache side, memory side, occupancy)
//   Optional build macro: WBUF_COALESCE_EN. When it is defined, a write that
//   hits a valid entry overwrites that entry's data in place. The head entry
//   is excluded from this while it is being written to memory.
module mem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 28,
  parameter int DW    = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  mem_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {C_IDLE, C_WAITRD, C_RESP, C_GAP} c_state_t;
  typedef enum logic [1:0] {M_IDLE, M_RD, M_WR, M_GAP}       m_state_t;

  c_state_t r_c_state, w_c_next;
  m_state_t r_m_state, w_m_next;

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             r_empty;
  logic [AW-1:0]    r_rd_addr;

  logic             r_c_ready, r_mem_read, r_mem_write;
  logic [DW-1:0]    r_c_rdata, r_mem_wdata;
  logic [AW-1:0]    r_mem_addr;

  logic             w_full, w_rd_hit, w_co_hit;
  logic [PW-1:0]    w_rd_idx, w_co_idx;
  logic             w_push, w_coal, w_fwd, w_rd_miss;
  logic             w_pop, w_rd_done, w_start_rd, w_start_wr;

  assign w_full = (r_count == CW'(DEPTH));

  // Scan from oldest (head) to newest so the last hit is the youngest match.
  always_comb begin
    w_rd_hit = 1'b0;
    w_rd_idx = r_rptr;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[r_rptr + PW'(i)] && (r_addr[r_rptr + PW'(i)] == bus.c_addr)) begin
        w_rd_hit = 1'b1;
        w_rd_idx = r_rptr + PW'(i);
      end
    end
  end

`ifdef WBUF_COALESCE_EN
  // The head is busy once its write has been launched, or is launching this
  // cycle, because mem_wdata is captured at launch.
  logic w_head_busy;
  assign w_head_busy = (r_m_state == M_WR) || w_start_wr;

  always_comb begin
    w_co_hit = 1'b0;
    w_co_idx = r_rptr;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[r_rptr + PW'(i)] && (r_addr[r_rptr + PW'(i)] == bus.c_addr) &&
          !(w_head_busy && (i == 0))) begin
        w_co_hit = 1'b1;
        w_co_idx = r_rptr + PW'(i);
      end
    end
  end
`else
  assign w_co_hit = 1'b0;
  assign w_co_idx = r_rptr;
`endif

  // Cache-side FSM: state register.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) r_c_state <= C_IDLE;
    else            r_c_state <= w_c_next;
  end

  // Cache-side FSM: next state. A write takes priority over a simultaneous read.
  always_comb begin
    w_c_next = r_c_state;
    case (r_c_state)
      C_IDLE: begin
        if (bus.c_write) begin
          if (w_co_hit || !w_full) w_c_next = C_RESP;
        end else if (bus.c_read) begin
          w_c_next = w_rd_hit ? C_RESP : C_WAITRD;
        end
      end
      C_WAITRD: if (w_rd_done) w_c_next = C_RESP;
      C_RESP:   w_c_next = C_GAP;
      C_GAP:    w_c_next = C_IDLE;
      default:  w_c_next = C_IDLE;
    endcase
  end

  // Cache-side FSM: output strobes.
  always_comb begin
    w_push    = 1'b0;
    w_coal    = 1'b0;
    w_fwd     = 1'b0;
    w_rd_miss = 1'b0;
    if (r_c_state == C_IDLE) begin
      if (bus.c_write) begin
        w_coal = w_co_hit;
        w_push = !w_co_hit && !w_full;
      end else if (bus.c_read) begin
        w_fwd     = w_rd_hit;
        w_rd_miss = !w_rd_hit;
      end
    end
  end

  // Memory-side FSM: state register.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) r_m_state <= M_IDLE;
    else            r_m_state <= w_m_next;
  end

  // Memory-side FSM: next state. A pending bypass read beats the drain.
  always_comb begin
    w_m_next = r_m_state;
    case (r_m_state)
      M_IDLE: begin
        if (r_c_state == C_WAITRD) w_m_next = M_RD;
        else if (r_count != '0)    w_m_next = M_WR;
      end
      M_RD, M_WR: if (bus.mem_ready) w_m_next = M_GAP;
      M_GAP:      w_m_next = M_IDLE;
      default:    w_m_next = M_IDLE;
    endcase
  end

  // Memory-side FSM: output strobes.
  always_comb begin
    w_start_rd = (r_m_state == M_IDLE) && (w_m_next == M_RD);
    w_start_wr = (r_m_state == M_IDLE) && (w_m_next == M_WR);
    w_pop      = (r_m_state == M_WR) && bus.mem_ready;
    w_rd_done  = (r_m_state == M_RD) && bus.mem_ready;
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry payload; it needs no reset because r_vld qualifies every use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= bus.c_addr;
      r_data[r_wptr] <= bus.c_wdata;
    end
    if (w_coal) r_data[w_co_idx] <= bus.c_wdata;
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_vld       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_rd_addr   <= '0;
      r_c_ready   <= 1'b0;
      r_c_rdata   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      // A push and a pop never hit the same slot: a push needs a free slot,
      // and a pop needs an occupied head.
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);

      if (w_rd_miss) r_rd_addr <= bus.c_addr;

      r_c_ready <= (w_c_next == C_RESP);
      if (w_fwd)          r_c_rdata <= r_data[w_rd_idx];
      else if (w_rd_done) r_c_rdata <= bus.mem_rdata;

      if (w_start_rd) begin
        r_mem_read <= 1'b1;
        r_mem_addr <= r_rd_addr;
      end
      if (w_start_wr) begin
        r_mem_write <= 1'b1;
        r_mem_addr  <= r_addr[r_rptr];
        r_mem_wdata <= r_data[r_rptr];
      end
      if (w_pop || w_rd_done) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end
    end
  end

  assign bus.c_ready   = r_c_ready;
  assign bus.c_rdata   = r_c_rdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.wb_count  = r_count;
  assign bus.wb_empty  = r_empty;
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer
//   Directed bench for mem_write_buffer: reset state, write latency and
//   drain, full-buffer stall, forwarding, bypass-read priority, request-hold
//   gap, async reset, and (with WBUF_COALESCE_EN) in-place coalescing.
module tb_mem_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 28;
  localparam int DW    = 128;

  logic clk;
  logic proc_reset;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [AW-1:0] log_a[$];
  logic [DW-1:0] log_d[$];

  mem_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  mem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a write-back and hold it until c_ready (bounded).
  task automatic cwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    bus.c_write = 1'b1;
    bus.c_addr  = a;
    bus.c_wdata = d;
    do begin
      tick();
      n++;
    end while (!bus.c_ready && n < 20);
    bus.c_write = 1'b0;
    if (!bus.c_ready) chk("cwrite_timeout", 128'(bus.c_ready), 128'(1));
  endtask

  // Acknowledge every memory write until the buffer is empty, logging order.
  task automatic drain();
    int n;
    n = 0;
    log_a.delete();
    log_d.delete();
    while ((bus.wb_count != 0 || bus.mem_write) && n < 200) begin
      if (bus.mem_write && !bus.mem_ready) begin
        log_a.push_back(bus.mem_addr);
        log_d.push_back(bus.mem_wdata);
        bus.mem_ready = 1'b1;
      end else begin
        bus.mem_ready = 1'b0;
      end
      tick();
      n++;
    end
    bus.mem_ready = 1'b0;
    if (n >= 200) chk("drain_timeout", 128'(n), 128'(0));
  endtask

  logic [DW-1:0] DA, D1, D2, DX, DY, RD;

  initial begin
    DA = {32{4'hA}};
    D1 = {4{32'hD1D1_0001}};
    D2 = {4{32'hD2D2_0002}};
    DX = {4{32'h1234_5678}};
    DY = {4{32'h9ABC_DEF0}};
    RD = {4{32'hCAFE_F00D}};

    bus.c_read = 1'b0; bus.c_write = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    proc_reset = 1'b1;
    tick(); tick();
    chk("rst_c_ready",   128'(bus.c_ready),   128'(0));
    chk("rst_c_rdata",   bus.c_rdata,         128'(0));
    chk("rst_mem_read",  128'(bus.mem_read),  128'(0));
    chk("rst_mem_write", 128'(bus.mem_write), 128'(0));
    chk("rst_mem_addr",  128'(bus.mem_addr),  128'(0));
    chk("rst_wb_count",  128'(bus.wb_count),  128'(0));
    chk("rst_wb_empty",  128'(bus.wb_empty),  128'(1));
    proc_reset = 1'b0;
    tick(); tick();

    // Single write, latency 1, then drain after an 8-cycle memory latency.
    bus.c_write = 1'b1; bus.c_addr = 28'h10; bus.c_wdata = DA;
    tick();
    chk("w1_c_ready",  128'(bus.c_ready),  128'(1));
    chk("w1_count",    128'(bus.wb_count), 128'(1));
    chk("w1_empty",    128'(bus.wb_empty), 128'(0));
    chk("w1_mw_early", 128'(bus.mem_write), 128'(0));
    bus.c_write = 1'b0;
    tick();
    chk("w1_c_ready_drop", 128'(bus.c_ready),  128'(0));
    chk("w1_mem_write",    128'(bus.mem_write), 128'(1));
    chk("w1_mem_addr",     128'(bus.mem_addr),  128'(28'h10));
    chk("w1_mem_wdata",    bus.mem_wdata,       DA);
    for (int i = 0; i < 7; i++) tick();
    chk("w1_mw_held", 128'(bus.mem_write), 128'(1));
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("w1_mw_drop", 128'(bus.mem_write), 128'(0));
    chk("w1_count0",  128'(bus.wb_count),  128'(0));
    chk("w1_empty1",  128'(bus.wb_empty),  128'(1));
    tick(); tick();

    // Fill with memory stalled, then a 5th write waits for a free slot.
    cwrite(28'h21, DX);
    cwrite(28'h22, DX);
    cwrite(28'h23, DX);
    cwrite(28'h24, DX);
    chk("full_count", 128'(bus.wb_count), 128'(4));
    bus.c_write = 1'b1; bus.c_addr = 28'h50; bus.c_wdata = DY;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_no_ready", 128'(bus.c_ready), 128'(0));
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("full_pop_no_ready", 128'(bus.c_ready),  128'(0));
    chk("full_pop_count",    128'(bus.wb_count), 128'(3));
    tick();
    chk("full_accept_ready", 128'(bus.c_ready),  128'(1));
    chk("full_accept_count", 128'(bus.wb_count), 128'(4));
    bus.c_write = 1'b0;
    drain();
    chk("full_drain_n",  128'(log_a.size()), 128'(4));
    if (log_a.size() == 4) begin
      chk("full_drain_a0", 128'(log_a[0]), 128'(28'h22));
      chk("full_drain_a3", 128'(log_a[3]), 128'(28'h50));
      chk("full_drain_d3", log_d[3],       DY);
    end
    tick(); tick();

    // Forwarding: youngest of two entries at 0x20 wins, no memory read.
    cwrite(28'h20, D1);
    cwrite(28'h20, D2);
    tick(); tick();
    bus.c_read = 1'b1; bus.c_addr = 28'h20;
    tick();
    chk("fwd_c_ready",  128'(bus.c_ready),  128'(1));
    chk("fwd_c_rdata",  bus.c_rdata,        D2);
    chk("fwd_mem_read", 128'(bus.mem_read), 128'(0));
    bus.c_read = 1'b0;
    drain();
    chk("dup_drain_n", 128'(log_d.size()), 128'(2));
    if (log_d.size() == 2) begin
      chk("dup_drain_d0", log_d[0], D1);
      chk("dup_drain_d1", log_d[1], D2);
    end
    tick(); tick();

    // Bypass read 0x40 goes ahead of the pending drain of 0x30.
    cwrite(28'h28, DX);
    cwrite(28'h30, DY);
    tick(); tick();
    bus.c_read = 1'b1; bus.c_addr = 28'h40;
    tick();
    chk("byp_no_ready", 128'(bus.c_ready), 128'(0));
    tick(); tick(); tick();
    chk("byp_busy_mr",   128'(bus.mem_read),  128'(0));
    chk("byp_busy_addr", 128'(bus.mem_addr),  128'(28'h28));
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("byp_pop_mw", 128'(bus.mem_write), 128'(0));
    tick();
    chk("byp_gap_mr", 128'(bus.mem_read), 128'(0));
    tick();
    chk("byp_mem_read",  128'(bus.mem_read),  128'(1));
    chk("byp_mem_addr",  128'(bus.mem_addr),  128'(28'h40));
    chk("byp_mw_behind", 128'(bus.mem_write), 128'(0));
    chk("byp_count",     128'(bus.wb_count),  128'(1));
    tick(); tick();
    bus.mem_rdata = RD; bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("byp_c_ready", 128'(bus.c_ready),  128'(1));
    chk("byp_c_rdata", bus.c_rdata,        RD);
    chk("byp_mr_drop", 128'(bus.mem_read), 128'(0));
    bus.c_read = 1'b0;
    drain();
    chk("byp_drain_n", 128'(log_a.size()), 128'(1));
    if (log_a.size() == 1) chk("byp_drain_a", 128'(log_a[0]), 128'(28'h30));
    tick(); tick();

    // Cache holds c_write one cycle past c_ready: exactly one push.
    bus.c_write = 1'b1; bus.c_addr = 28'h70; bus.c_wdata = DX;
    tick();
    chk("hold_ready", 128'(bus.c_ready), 128'(1));
    tick();
    chk("hold_ready_drop", 128'(bus.c_ready), 128'(0));
    bus.c_write = 1'b0;
    tick(); tick();
    chk("hold_count", 128'(bus.wb_count), 128'(1));

    // Async reset in the middle of a memory write with 3 entries.
    cwrite(28'h71, DX);
    cwrite(28'h72, DX);
    chk("arst_pre_count", 128'(bus.wb_count),  128'(3));
    chk("arst_pre_mw",    128'(bus.mem_write), 128'(1));
    proc_reset = 1'b1;
    #1;
    chk("arst_mw",      128'(bus.mem_write), 128'(0));
    chk("arst_count",   128'(bus.wb_count),  128'(0));
    chk("arst_empty",   128'(bus.wb_empty),  128'(1));
    chk("arst_c_ready", 128'(bus.c_ready),   128'(0));
    #1;
    proc_reset = 1'b0;
    tick(); tick(); tick();
    chk("arst_post_mw", 128'(bus.mem_write), 128'(0));

`ifdef WBUF_COALESCE_EN
    // 0x5F occupies the memory; two writes to 0x60 merge into one entry.
    cwrite(28'h5F, DX);
    cwrite(28'h60, D1);
    cwrite(28'h60, D2);
    chk("coal_count", 128'(bus.wb_count), 128'(2));
    drain();
    chk("coal_drain_n", 128'(log_a.size()), 128'(2));
    if (log_a.size() == 2) begin
      chk("coal_a1", 128'(log_a[1]), 128'(28'h60));
      chk("coal_d1", log_d[1],       D2);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
